// File: rtl/gf256_pkg.sv
// GF(256) arithmetic over x^8+x^4+x^3+x+1 with generator alpha = 0x03.
// Shared by the syndrome datapath and its constant multipliers.
package gf256_pkg;

  localparam logic [8:0] GF_POLY  = 9'h11B;
  localparam logic [7:0] GF_ALPHA = 8'h03;

  // Shift-and-reduce product of two field elements.
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      if (x[7]) x = {x[6:0], 1'b0} ^ GF_POLY[7:0];
      else      x = {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // alpha^(e mod 255); used only for elaboration-time constants.
  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] r;
    int         k;
    r = 8'h01;
    k = e % 255;
    for (int i = 0; i < k; i++) r = gf_mul(r, GF_ALPHA);
    return r;
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational 8x8 GF(256) multiplier.
// One instance per syndrome cell; the b operand is a constant root.
module gf256_mul
  import gf256_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);

  always_comb begin
    o_p = gf_mul(i_a, i_b);
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome front end: Horner accumulation of NSYM
// syndromes per codeword, snapshotted behind a valid/ready port.
module rs_syndrome_calc
  import gf256_pkg::*;
#(
  parameter int N    = 255,
  parameter int NSYM = 16,
  parameter int FCR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*NSYM-1:0] out_synd,
  output logic              out_nonzero,
  output logic              out_len_err
);

  localparam int SW = 8 * NSYM;

  logic [SW-1:0] r_acc;
  logic          r_first;
  logic [8:0]    r_cnt;

  logic [SW-1:0] r_synd;
  logic          r_nonzero;
  logic          r_len_err;
  logic          r_out_valid;

  logic [SW-1:0] w_next;
  logic [8:0]    w_cnt_inc;
  logic          w_accept;
  logic          w_close;
  logic          w_drain;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_close     = w_accept && in_last;
  assign w_drain     = r_out_valid && out_ready;

  assign out_valid   = r_out_valid;
  assign out_synd    = r_synd;
  assign out_nonzero = r_nonzero;
  assign out_len_err = r_len_err;

  // First symbol of a codeword seeds the accumulator directly.
  for (genvar j = 0; j < NSYM; j++) begin : g_cell
    localparam logic [7:0] ALPHA_J = gf_pow((FCR + j) % 255);
    logic [7:0] w_prod;

    gf256_mul u_mul (
      .i_a (r_acc[8*j +: 8]),
      .i_b (ALPHA_J),
      .o_p (w_prod)
    );

    assign w_next[8*j +: 8] =
      (r_first ? 8'h00 : w_prod) ^ in_data;
  end

  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt != 9'h1FF) w_cnt_inc = r_cnt + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_first <= 1'b1;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_acc <= w_next;
      if (in_last) begin
        r_first <= 1'b1;
        r_cnt   <= '0;
      end else begin
        r_first <= 1'b0;
        r_cnt   <= w_cnt_inc;
      end
    end
  end

  // A closing symbol may load while the previous vector drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_synd      <= '0;
      r_nonzero   <= 1'b0;
      r_len_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_close) begin
      r_synd      <= w_next;
      r_nonzero   <= |w_next;
      r_len_err   <= (w_cnt_inc != 9'(N));
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: directed cases plus random codewords
// against a direct polynomial-evaluation model (FCR=0 and FCR=1).
module tb_rs_syndrome_calc;

  localparam int N    = 255;
  localparam int NSYM = 16;
  localparam int W    = 8 * NSYM;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready0, in_ready1;
  logic         out_valid0, out_valid1;
  logic [W-1:0] synd0, synd1;
  logic         nz0, nz1, le0, le1;

  rs_syndrome_calc #(.N(N), .NSYM(NSYM), .FCR(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_synd(synd0), .out_nonzero(nz0), .out_len_err(le0)
  );

  rs_syndrome_calc #(.N(N), .NSYM(NSYM), .FCR(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_synd(synd1), .out_nonzero(nz1), .out_len_err(le1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic         nz0;
    logic         nz1;
    logic         le;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] cw[$];
  logic [7:0] expt[0:254];
  int         lg[0:255];
  bit         rnd_rdy = 1'b0;

  function automatic logic [7:0] mul3(input logic [7:0] x);
    logic [7:0] d;
    d = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    return d ^ x;
  endfunction

  // S_j = sum_i r_i * alpha^((fcr+j)*(L-1-i)), via log/antilog tables.
  function automatic logic [W-1:0] model(input int fcr);
    logic [W-1:0] s;
    logic [7:0]   a;
    int           L;
    s = '0;
    L = cw.size();
    for (int j = 0; j < NSYM; j++) begin
      a = 8'h00;
      for (int i = 0; i < L; i++)
        if (cw[i] != 8'h00)
          a ^= expt[(lg[cw[i]] + ((fcr + j) % 255) * (L - 1 - i)) % 255];
      s[8*j +: 8] = a;
    end
    return s;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.s0  = model(0);
    e.s1  = model(1);
    e.nz0 = |e.s0;
    e.nz1 = |e.s1;
    e.le  = (cw.size() != N);
    expq.push_back(e);
  endtask

  task automatic mk(input int len, input bit rnd);
    cw.delete();
    for (int i = 0; i < len; i++)
      cw.push_back(rnd ? 8'($urandom) : 8'h00);
  endtask

  // Entered and left at posedge+1.
  task automatic send(input bit gap, input bit no_last,
                      output int cyc);
    int i, L, stall;
    bit acc;
    i = 0;
    L = cw.size();
    stall = 0;
    cyc = 0;
    while (i < L) begin
      if (gap && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b1;
        in_data  = cw[i];
        in_last  = !no_last && (i == L - 1);
      end
      @(negedge clk);
      acc = in_valid && in_ready0;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        stall = 0;
        if (in_last) begin
          push_exp();
          chk("lat", W'(out_valid0), W'(1));
        end
        i++;
      end else if (in_valid) begin
        stall++;
        if (stall > 1000) begin
          chk("stall", W'(stall), W'(0));
          break;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  bit           hold_pend = 1'b0;
  logic [W-1:0] hold_s;
  exp_t         got_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_v", W'(out_valid0), W'(1));
        chk("hold_s", synd0, hold_s);
      end
      chk("rdy", W'(in_ready0), W'(!out_valid0 || out_ready));
      chk("rdy1", W'(in_ready1), W'(in_ready0));
      hold_pend = out_valid0 && !out_ready;
      hold_s    = synd0;
      if (out_valid0 && out_ready) begin
        if (expq.size() == 0) begin
          chk("spur", W'(out_valid0), W'(0));
        end else begin
          got_e = expq.pop_front();
          chk("s0", synd0, got_e.s0);
          chk("s1", synd1, got_e.s1);
          chk("nz0", W'(nz0), W'(got_e.nz0));
          chk("nz1", W'(nz1), W'(got_e.nz1));
          chk("le0", W'(le0), W'(got_e.le));
          chk("le1", W'(le1), W'(got_e.le));
          chk("v1", W'(out_valid1), W'(1));
        end
      end
    end
  end

  logic [W-1:0] held;
  logic [W-1:0] rep5a;
  int           cyc;
  int           len;

  initial begin
    expt[0] = 8'h01;
    lg[1]   = 0;
    for (int i = 1; i < 255; i++) begin
      expt[i] = mul3(expt[i-1]);
      lg[expt[i]] = i;
    end
    rep5a = {NSYM{8'h5A}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_v", W'(out_valid0), W'(0));
    chk("rst_s", synd0, '0);
    chk("rst_nz", W'(nz0), W'(0));
    chk("rst_le", W'(le0), W'(0));
    chk("rst_rdy", W'(in_ready0), W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    mk(N, 1'b0);
    send(1'b0, 1'b0, cyc);
    chk("zero_s", synd0, '0);
    chk("zero_nz", W'(nz0), W'(0));
    chk("zero_le", W'(le0), W'(0));

    mk(N, 1'b0);
    cw[0] = 8'h01;
    send(1'b0, 1'b0, cyc);
    chk("imp_s0", W'(synd0[7:0]), W'(8'h01));
    chk("imp_s1", W'(synd0[15:8]), W'(8'hF6));
    chk("imp_s2", W'(synd0[23:16]), W'(8'h52));
    chk("imp_nz", W'(nz0), W'(1));

    mk(N, 1'b0);
    cw[N-1] = 8'h5A;
    send(1'b0, 1'b0, cyc);
    chk("last_f0", synd0, rep5a);
    chk("last_f1", synd1, rep5a);

    mk(10, 1'b1);
    send(1'b0, 1'b0, cyc);
    chk("short_le", W'(le0), W'(1));

    mk(1, 1'b1);
    send(1'b0, 1'b0, cyc);
    chk("one_s", synd0, {NSYM{cw[0]}});
    chk("one_le", W'(le0), W'(1));

    mk(260, 1'b1);
    send(1'b0, 1'b0, cyc);
    chk("long_le", W'(le0), W'(1));

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    mk(N, 1'b1);
    send(1'b0, 1'b0, cyc);
    held = synd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_rdy", W'(in_ready0), W'(0));
      chk("bp_s", synd0, held);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    mk(N, 1'b1);
    send(1'b0, 1'b0, cyc);
    chk("b2b_cyc", W'(cyc), W'(N));

    @(posedge clk);
    #1;
    mk(100, 1'b1);
    send(1'b0, 1'b1, cyc);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_v", W'(out_valid0), W'(0));
    @(posedge clk);
    #1;
    mk(N, 1'b0);
    send(1'b0, 1'b0, cyc);
    chk("mrst_s", synd0, '0);
    chk("mrst_le", W'(le0), W'(0));

    rnd_rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 300)) : N;
      mk(len, 1'b1);
      send(1'b1, 1'b0, cyc);
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && expq.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain", W'(expq.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
